// File: rtl/bullet_hit_scanner_if.sv
// Collision read port between the bullet store (slave) and the hit scanner (master).
// Handshake: the scanner drives bullet_index as a plain address and the store answers
// combinationally in the same cycle; is_collide is a one-cycle retire strobe for the addressed slot.
interface bullet_hit_scanner_if;
  logic [15:0] bullet_pos;
  logic [15:0] bullet_size;
  logic [1:0]  bullet_color;
  logic        bullet_render;
  logic [2:0]  bullet_index;
  logic        is_collide;

  modport master (
    input  bullet_pos, bullet_size, bullet_color, bullet_render,
    output bullet_index, is_collide
  );

  modport slave (
    output bullet_pos, bullet_size, bullet_color, bullet_render,
    input  bullet_index, is_collide
  );
endinterface

// File: rtl/bullet_hit_scanner.sv
// Walks the bullet store slot by slot, retires bullets that hit the player and tracks HP,
// invulnerability and death. Optional feature macro: BLUE_MOVE_RULE_EN (blue hurts only a moving player).
module bullet_hit_scanner #(
  parameter int NUM_BULLETS   = 3,
  parameter int MAX_HP        = 20,
  parameter int DAMAGE        = 2,
  parameter int HEAL          = 1,
  parameter int INVULN_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_run,
  input  logic [15:0]              player_pos,
  input  logic [15:0]              player_size,
  input  logic                     player_moving,
  bullet_hit_scanner_if.master     store,
  output logic [7:0]               hp,
  output logic                     is_dead,
  output logic                     invuln,
  output logic [2:0]               dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_HIT   = 3'd3;
  localparam logic [2:0] S_DEAD  = 3'd4;

  localparam int              CNT_W    = $clog2(INVULN_CYCLES + 1);
  localparam logic [2:0]      IDX_LAST = 3'(NUM_BULLETS - 1);
  localparam logic [7:0]      MAX_HP_V = 8'(MAX_HP);
  localparam logic [7:0]      DAMAGE_V = 8'(DAMAGE);
  localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [1:0]       color_q, color_d;
  logic [7:0]       hp_q, hp_d;
  logic             dead_q, dead_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Box edges widened to 9 bits so boxes near the 255 border do not wrap.
  logic [8:0] px, py, bx, by, px_end, py_end, bx_end, by_end;
  logic       overlap;

  assign px     = {1'b0, player_pos[15:8]};
  assign py     = {1'b0, player_pos[7:0]};
  assign bx     = {1'b0, store.bullet_pos[15:8]};
  assign by     = {1'b0, store.bullet_pos[7:0]};
  assign px_end = px + {1'b0, player_size[15:8]};
  assign py_end = py + {1'b0, player_size[7:0]};
  assign bx_end = bx + {1'b0, store.bullet_size[15:8]};
  assign by_end = by + {1'b0, store.bullet_size[7:0]};
  assign overlap = (px < bx_end) && (bx < px_end) && (py < by_end) && (by < py_end);

  logic       blue_ok;
`ifdef BLUE_MOVE_RULE_EN
  assign blue_ok = player_moving;
`else
  logic unused_moving;
  assign unused_moving = player_moving;
  assign blue_ok       = 1'b1;
`endif

  logic       inv_active, is_green, accept;
  logic [8:0] hp_heal;
  logic [7:0] hp_healed, hp_damaged;
  logic [2:0] idx_next;

  assign inv_active = (cnt_q != '0);
  assign is_green   = (color_q == 2'b01);
  assign accept     = hit_q && (is_green || (!inv_active && ((color_q != 2'b10) || blue_ok)));
  assign hp_heal    = {1'b0, hp_q} + 9'(HEAL);
  assign hp_healed  = (hp_heal > 9'(MAX_HP)) ? MAX_HP_V : hp_heal[7:0];
  assign hp_damaged = (hp_q > DAMAGE_V) ? (hp_q - DAMAGE_V) : 8'd0;
  assign idx_next   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    color_d = color_q;
    hp_d    = hp_q;
    dead_d  = dead_q;
    cnt_d   = (inv_active && state_q != S_IDLE) ? cnt_q - 1'b1 : cnt_q;

    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        if (is_run) state_d = S_CHECK;
      end
      S_CHECK: begin
        hit_d   = overlap && store.bullet_render;
        color_d = store.bullet_color;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (accept) begin
          state_d = S_HIT;
          // HP and invuln move on the edge that raises is_collide.
          if (is_green) begin
            hp_d = hp_healed;
          end else begin
            hp_d   = hp_damaged;
            dead_d = (hp_damaged == 8'd0);
            cnt_d  = INV_LOAD;
          end
        end else begin
          idx_d   = idx_next;
          state_d = S_CHECK;
        end
      end
      S_HIT: begin
        if (hp_q == 8'd0) begin
          state_d = S_DEAD;
        end else begin
          idx_d   = idx_next;
          state_d = S_CHECK;
        end
      end
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase

    if (!is_run) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      hit_d   = 1'b0;
      hp_d    = MAX_HP_V;
      dead_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      hit_q   <= 1'b0;
      color_q <= 2'b00;
      hp_q    <= MAX_HP_V;
      dead_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      color_q <= color_d;
      hp_q    <= hp_d;
      dead_q  <= dead_d;
      cnt_q   <= cnt_d;
    end
  end

  assign store.bullet_index = idx_q;
  assign store.is_collide   = (state_q == S_HIT);
  assign hp                 = hp_q;
  assign is_dead            = dead_q;
  assign invuln             = inv_active;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Bench for bullet_hit_scanner: a small bullet-store model feeds the read port and
// retires slots on is_collide; expected pulses (index, new hp) are queued and matched.
module tb_bullet_hit_scanner;
  localparam int W = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_run;
  logic [15:0] player_pos;
  logic [15:0] player_size;
  logic        player_moving;
  logic [7:0]  hp;
  logic        is_dead;
  logic        invuln;
  logic [2:0]  dbg_state;

  bullet_hit_scanner_if bif();

  bullet_hit_scanner dut (
    .clk          (clk),
    .reset        (reset),
    .is_run       (is_run),
    .player_pos   (player_pos),
    .player_size  (player_size),
    .player_moving(player_moving),
    .store        (bif.master),
    .hp           (hp),
    .is_dead      (is_dead),
    .invuln       (invuln),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  // Store model
  logic [7:0] sx[8], sy[8], sw[8], sh[8];
  logic [1:0] sc[8];
  logic [7:0] slot_live;
  logic [7:0] slot_kill;
  logic       kill_clr;

  assign bif.bullet_pos    = {sx[bif.bullet_index], sy[bif.bullet_index]};
  assign bif.bullet_size   = {sw[bif.bullet_index], sh[bif.bullet_index]};
  assign bif.bullet_color  = sc[bif.bullet_index];
  assign bif.bullet_render = slot_live[bif.bullet_index] & ~slot_kill[bif.bullet_index];

  always @(posedge clk) begin
    if (kill_clr) slot_kill <= '0;
    else if (bif.is_collide === 1'b1) slot_kill[bif.bullet_index] <= 1'b1;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic monitor_pulses();
    forever begin
      @(negedge clk);
      if (bif.is_collide === 1'b1) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {bif.bullet_index, hp};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got idx=%0d hp=%0d, required no pulse", bif.bullet_index, hp);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL pulse: got idx=%0d hp=%0d, required idx=%0d hp=%0d",
                     got[10:8], got[7:0], want[10:8], want[7:0]);
          end
        end
      end
    end
  endtask

  task automatic set_player(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h);
    player_pos  = {x, y};
    player_size = {w, h};
  endtask

  task automatic set_slot(input int i, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [1:0] c, input logic live);
    sx[i] = x; sy[i] = y; sw[i] = w; sh[i] = h; sc[i] = c;
    slot_live[i] = live;
  endtask

  task automatic represent();
    kill_clr = 1'b1;
    @(negedge clk);
    kill_clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d pulses outstanding after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_invuln_clear();
    int n;
    n = 0;
    while (invuln === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (invuln !== 1'b0) begin
      errors++;
      $display("FAIL invuln_clear: invuln=%b after 40 cycles, required 0", invuln);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    is_run = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bif.bullet_index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d, required 0", bif.bullet_index); end
    if (bif.is_collide !== 1'b0) begin errors++; $display("FAIL reset_collide: got %b, required 0", bif.is_collide); end
    if (hp !== 8'd20) begin errors++; $display("FAIL reset_hp: got %0d, required 20", hp); end
    if (is_dead !== 1'b0) begin errors++; $display("FAIL reset_dead: got %b, required 0", is_dead); end
    if (invuln !== 1'b0) begin errors++; $display("FAIL reset_invuln: got %b, required 0", invuln); end
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_scan();
    int exp_seq[7] = '{0, 0, 1, 1, 2, 2, 0};
    is_run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (bif.bullet_index !== 3'(exp_seq[i])) begin
        errors++;
        $display("FAIL scan_index[%0d]: got %0d, required %0d", i, bif.bullet_index, exp_seq[i]);
      end
    end
    checks++;
    if (hp !== 8'd20) begin errors++; $display("FAIL scan_hp: got %0d, required 20", hp); end
  endtask

  task automatic test_white_invuln();
    int n;
    int cnt;
    set_player(8'hA4, 8'h10, 8'd8, 8'd8);
    exp_q.push_back({3'd1, 8'd18});
    set_slot(1, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b00, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.is_collide !== 1'b1 && n < 40);
    checks++;
    if (bif.is_collide !== 1'b1) begin
      errors++;
      $display("FAIL white_pulse_timeout: no pulse in 40 cycles, required pulse at idx 1");
      exp_q.delete();
      return;
    end
    // Slot comes back live while invuln is running: must be ignored until it ends.
    kill_clr = 1'b1;
    exp_q.push_back({3'd1, 8'd16});
    cnt = 0;
    while (invuln === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      kill_clr = 1'b0;
    end
    kill_clr = 1'b0;
    checks += 3;
    if (cnt != 16) begin errors++; $display("FAIL invuln_len: got %0d cycles, required 16", cnt); end
    if (exp_q.size() != 1) begin errors++; $display("FAIL invuln_block: got %0d pending, required 1", exp_q.size()); end
    if (hp !== 8'd18) begin errors++; $display("FAIL invuln_hp: got %0d, required 18", hp); end
    wait_drain(40);
    checks++;
    if (hp !== 8'd16) begin errors++; $display("FAIL white_second_hp: got %0d, required 16", hp); end
  endtask

  task automatic test_green();
    slot_live = '0;
    is_run = 1'b0;
    @(negedge clk);
    checks += 4;
    if (hp !== 8'd20) begin errors++; $display("FAIL reload_hp: got %0d, required 20", hp); end
    if (is_dead !== 1'b0) begin errors++; $display("FAIL reload_dead: got %b, required 0", is_dead); end
    if (invuln !== 1'b0) begin errors++; $display("FAIL reload_invuln: got %b, required 0", invuln); end
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reload_state: got %0d, required 0", dbg_state); end
    is_run = 1'b1;
    represent();
    exp_q.push_back({3'd0, 8'd20});
    set_slot(0, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b01, 1'b1);
    wait_drain(40);
    checks++;
    if (hp !== 8'd20) begin errors++; $display("FAIL green_at_max: got %0d, required 20", hp); end
    slot_live[0] = 1'b0;
    exp_q.push_back({3'd2, 8'd18});
    set_slot(2, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b00, 1'b1);
    wait_drain(40);
    checks++;
    if (invuln !== 1'b1) begin errors++; $display("FAIL damage_invuln: got %b, required 1", invuln); end
    slot_live[2] = 1'b0;
    wait_invuln_clear();
    exp_q.push_back({3'd0, 8'd19});
    slot_live[0] = 1'b1;
    represent();
    wait_drain(40);
    checks += 2;
    if (hp !== 8'd19) begin errors++; $display("FAIL green_heal: got %0d, required 19", hp); end
    if (invuln !== 1'b0) begin errors++; $display("FAIL green_invuln: got %b, required 0", invuln); end
    slot_live = '0;
  endtask

  task automatic test_edge_touch();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_player(8'h40, 8'h10, 8'd8, 8'd8);
      else        set_player(8'h30, 8'h08, 8'd8, 8'd8);
      set_slot(0, 8'h30, 8'h10, 8'd16, 8'd16, 2'b00, 1'b1);
      represent();
      repeat (20) @(negedge clk);
      checks += 2;
      if (hp !== 8'd19) begin errors++; $display("FAIL edge_hp[%0d]: got %0d, required 19", k, hp); end
      if (invuln !== 1'b0) begin errors++; $display("FAIL edge_invuln[%0d]: got %b, required 0", k, invuln); end
    end
    slot_live = '0;
  endtask

  task automatic test_wrap_sum();
    set_player(8'hFC, 8'h10, 8'd4, 8'd8);
    exp_q.push_back({3'd2, 8'd17});
    set_slot(2, 8'hF8, 8'h13, 8'd16, 8'd16, 2'b00, 1'b1);
    represent();
    wait_drain(40);
    checks++;
    if (hp !== 8'd17) begin errors++; $display("FAIL wrap_hp: got %0d, required 17", hp); end
    slot_live = '0;
    wait_invuln_clear();
  endtask

  task automatic test_blue();
    set_player(8'hA4, 8'h10, 8'd8, 8'd8);
    player_moving = 1'b0;
`ifdef BLUE_MOVE_RULE_EN
    set_slot(0, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b10, 1'b1);
    represent();
    repeat (24) @(negedge clk);
    checks += 2;
    if (hp !== 8'd17) begin errors++; $display("FAIL blue_still_hp: got %0d, required 17", hp); end
    if (invuln !== 1'b0) begin errors++; $display("FAIL blue_still_invuln: got %b, required 0", invuln); end
    exp_q.push_back({3'd0, 8'd15});
    player_moving = 1'b1;
`else
    exp_q.push_back({3'd0, 8'd15});
    set_slot(0, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b10, 1'b1);
    represent();
`endif
    wait_drain(40);
    checks++;
    if (hp !== 8'd15) begin errors++; $display("FAIL blue_hp: got %0d, required 15", hp); end
    player_moving = 1'b0;
    slot_live = '0;
    wait_invuln_clear();
  endtask

  task automatic test_death();
    logic [2:0] idx0;
    int h;
    is_run = 1'b0;
    @(negedge clk);
    is_run = 1'b1;
    set_player(8'hA4, 8'h10, 8'd8, 8'd8);
    for (int k = 0; k < 10; k++) begin
      h = 18 - 2 * k;
      slot_live = '0;
      exp_q.push_back({3'(k % 3), 8'(h)});
      set_slot(k % 3, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b00, 1'b1);
      represent();
      wait_drain(40);
      if (h != 0) wait_invuln_clear();
    end
    repeat (3) @(negedge clk);
    checks += 3;
    if (is_dead !== 1'b1) begin errors++; $display("FAIL dead_flag: got %b, required 1", is_dead); end
    if (hp !== 8'd0) begin errors++; $display("FAIL dead_hp: got %0d, required 0", hp); end
    if (dbg_state !== 3'd4) begin errors++; $display("FAIL dead_state: got %0d, required 4", dbg_state); end
    idx0 = bif.bullet_index;
    for (int i = 0; i < 3; i++) set_slot(i, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b01, 1'b1);
    represent();
    repeat (12) @(negedge clk);
    checks += 2;
    if (bif.bullet_index !== idx0) begin errors++; $display("FAIL dead_halt: got idx %0d, required %0d", bif.bullet_index, idx0); end
    if (hp !== 8'd0) begin errors++; $display("FAIL dead_no_heal: got %0d, required 0", hp); end
    slot_live = '0;
    is_run = 1'b0;
    @(negedge clk);
    checks += 2;
    if (hp !== 8'd20) begin errors++; $display("FAIL revive_hp: got %0d, required 20", hp); end
    if (is_dead !== 1'b0) begin errors++; $display("FAIL revive_dead: got %b, required 0", is_dead); end
    is_run = 1'b1;
  endtask

  task automatic test_reset_mid_hit();
    int n;
    represent();
    exp_q.push_back({3'd1, 8'd18});
    set_slot(1, 8'hA0, 8'h13, 8'd16, 8'd16, 2'b00, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bif.is_collide !== 1'b1 && n < 40);
    checks++;
    if (bif.is_collide !== 1'b1) begin
      errors++;
      $display("FAIL mid_hit_timeout: no pulse in 40 cycles, required pulse at idx 1");
      exp_q.delete();
    end
    reset = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bif.is_collide !== 1'b0) begin errors++; $display("FAIL mid_hit_collide: got %b, required 0", bif.is_collide); end
    if (hp !== 8'd20) begin errors++; $display("FAIL mid_hit_hp: got %0d, required 20", hp); end
    if (invuln !== 1'b0) begin errors++; $display("FAIL mid_hit_invuln: got %b, required 0", invuln); end
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL mid_hit_state: got %0d, required 0", dbg_state); end
    reset = 1'b0;
    slot_live = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    is_run = 1'b0;
    player_moving = 1'b0;
    kill_clr = 1'b1;
    slot_live = '0;
    for (int i = 0; i < 8; i++) set_slot(i, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    set_player(8'hA4, 8'h10, 8'd8, 8'd8);
    fork
      monitor_pulses();
    join_none
    test_reset();
    kill_clr = 1'b0;
    test_idle_scan();
    test_white_invuln();
    test_green();
    test_edge_touch();
    test_wrap_sum();
    test_blue();
    test_death();
    test_reset_mid_hit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_hit_scanner.md
# bullet_hit_scanner

Downstream consumer of the bullet store. Sequentially walks every bullet slot through the store's collision read port and tests each rendered bullet's box against the player box. On a valid hit it pulses the store's collide input to retire that bullet and applies colour-dependent damage or healing to player HP. It also owns the post-hit invulnerability window and the death flag.

## Interface
Parameters:
- NUM_BULLETS, 3: number of bullet slots scanned, indices 0..NUM_BULLETS-1.
- MAX_HP, 20: HP value after reset or reload, and the heal ceiling.
- DAMAGE, 2: HP removed per damaging hit.
- HEAL, 1: HP added per green hit.
- INVULN_CYCLES, 16: length of the post-damage invulnerability window, in clk cycles.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- is_run  in  1  game running. Low holds the block in reload (same semantics as the store's isRun).
- player_pos  in  16  player box origin: [15:8] x, [7:0] y.
- player_size  in  16  player box size: [15:8] width, [7:0] height.
- player_moving  in  1  player moved during the current frame.
- bullet_pos  in  16  position of the slot at bullet_index: [15:8] x, [7:0] y. Combinational read, valid in the same cycle.
- bullet_size  in  16  size of that slot: [15:8] w, [7:0] h.
- bullet_color  in  2  colour of that slot: 00 white, 01 green, 10 blue, 11 treated as white.
- bullet_render  in  1  slot is live.
- bullet_index  out  3  slot currently addressed; drives the store's index2.
- is_collide  out  1  one-cycle retire pulse for the slot at bullet_index.
- hp  out  8  current player HP.
- is_dead  out  1  sticky flag; set when hp reaches 0.
- invuln  out  1  high while the invulnerability counter is non-zero.

## Operation
- States: IDLE, CHECK, EVAL, HIT, DEAD.
- IDLE: bullet_index=0. Moves to CHECK on the first cycle with is_run=1.
- CHECK: computes overlap combinationally and registers it into a hit flag together with the colour.
  - Overlap rule (strict; edges touching is a miss): px < bx+bw and bx < px+pw and py < by+bh and by < py+ph.
  - All sums are 9 bits, so there is no 8-bit wrap.
  - hit = overlap and bullet_render.
- EVAL:
  - A hit is accepted when: colour is green; or colour is white and invuln=0; or colour is blue (see Configuration) and invuln=0.
  - Accepted hit: go to HIT.
  - Otherwise: advance bullet_index and return to CHECK. After NUM_BULLETS-1 the index wraps to 0.
- HIT: is_collide=1 for exactly one cycle with bullet_index unchanged.
  - Damage: hp = max(hp-DAMAGE, 0), and the invuln counter loads INVULN_CYCLES.
  - Green: hp = min(hp+HEAL, MAX_HP); the invuln counter is not touched.
  - Next state: DEAD if the new hp is 0; otherwise the index advances (with wrap) and the FSM returns to CHECK.
- DEAD: is_dead=1, is_collide=0, scanning stops. Exits only on reset or is_run=0.
- is_run=0 in any state, next cycle:
  - state goes to IDLE;
  - hp=MAX_HP, is_dead=0;
  - the invuln counter clears;
  - is_collide=0.
- The invuln counter decrements once per cycle while non-zero, in every state except IDLE.

## Timing
- Reset values: bullet_index=0, is_collide=0, hp=MAX_HP, is_dead=0, invuln=0, state IDLE.
- Reset has priority over is_run. A reset mid-HIT cancels the pulse on the next edge.
- Scan cost per slot: 2 cycles on a miss, 3 cycles on a hit. A full pass of NUM_BULLETS=3 with no hits takes 6 cycles.
- bullet_index is stable throughout CHECK, EVAL and HIT, so the store clears the correct slot.
- hp, invuln and is_dead update on the same edge on which is_collide rises.
- Simultaneous events:
  - The invuln counter reload wins over its decrement.
  - Heal is applied at MAX_HP with no change.
  - Damage with hp ≤ DAMAGE yields hp=0 and is_dead=1 on the next edge.

## Configuration
- BLUE_MOVE_RULE_EN defined: a blue hit is accepted only when player_moving=1 and invuln=0. A blue hit while the player is stationary is ignored: no pulse, and the bullet stays live.
- BLUE_MOVE_RULE_EN undefined: blue is treated exactly as white.

## Test plan
- Reset, then is_run=1, with all renders 0 → bullet_index cycles 0,0,1,1,2,2,0…; is_collide never rises; hp=20.
- Slot 1 white, pos (0xA0,0x13), size 16×16; player (0xA4,0x10), size 8×8 → one is_collide pulse at index 1; hp=18; invuln high for 16 cycles.
- Same overlap re-presented during invuln → no pulse; hp stays 18. After invuln drops, the next scan of slot 1 pulses; hp=16.
- Green overlap with hp=20 → pulse, hp stays 20. Green overlap with hp=18 → pulse, hp=19, invuln unchanged.
- Player box edge exactly touching a bullet (px = bx+bw) → no pulse. Damage with hp=2 → hp=0, is_dead=1, scanning halts. Then is_run=0 → hp=20, is_dead=0.
- With BLUE_MOVE_RULE_EN defined, blue overlap with player_moving=0 → no pulse. With player_moving=1 → pulse, hp-2. With the macro undefined, blue overlap with player_moving=0 → pulse.
